// File: rtl/load_store_unit_if.sv
// Word-wide data memory bus between the load/store unit and memory.
// master: LSU drives req/we/addr/be/wdata; slave: memory drives rdata/ack.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-enabled word accesses, load extension, core stall, ack timeout.
// Ports: clk, reset (sync, active-high); core side MemRead/MemWrite/Funct3/Addr/WrData ->
// LoadData/Stall/Done/BusErr/Misaligned; memory side through load_store_unit_if.master bus.
// Optional macro MISALIGN_TRAP_EN: trap misaligned H/W accesses without touching memory.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [2:0]               Funct3,
    input  logic [31:0]              Addr,
    input  logic [31:0]              WrData,
    output logic [31:0]              LoadData,
    output logic                     Stall,
    output logic                     Done,
    output logic                     BusErr,
    output logic                     Misaligned,
    load_store_unit_if.master        bus
);

    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   addr_q,  addr_d;
    logic [2:0]    f3_q,    f3_d;
    logic          we_q,    we_d;
    logic [3:0]    be_q,    be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   ld_q,    ld_d;
    logic          berr_q,  berr_d;
    logic          mis_q,   mis_d;

    logic          req;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   rd_sh;
    logic [15:0]   rd_h;
    logic [31:0]   ld_fmt;
    logic          misal;

    assign req = MemRead | MemWrite;

    // Lane placement for the incoming request, computed from the live core inputs
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = WrData;
        if (MemWrite) begin
            unique case (1'b1)
                (Funct3[1:0] == 2'b00): begin
                    st_be    = 4'b0001 << Addr[1:0];
                    st_wdata = {4{WrData[7:0]}};
                end
                (Funct3[1:0] == 2'b01): begin
                    st_be    = Addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{WrData[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = WrData;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        unique case (1'b1)
            (Funct3[1:0] == 2'b00): misal = 1'b0;
            (Funct3[1:0] == 2'b01): misal = Addr[0];
            default:                misal = (Addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misal = 1'b0;
`endif

    // Load extraction uses the captured address/size, not the live inputs
    assign rd_sh = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    assign rd_h  = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        unique case (1'b1)
            (f3_q[1:0] == 2'b00):
                ld_fmt = f3_q[2] ? {24'd0, rd_sh[7:0]}
                                 : {{24{rd_sh[7]}}, rd_sh[7:0]};
            (f3_q[1:0] == 2'b01):
                ld_fmt = f3_q[2] ? {16'd0, rd_h}
                                 : {{16{rd_h[15]}}, rd_h};
            default:
                ld_fmt = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        berr_d  = berr_q;
        mis_d   = mis_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = Addr;
                    f3_d    = Funct3;
                    we_d    = MemWrite;
                    be_d    = st_be;
                    wdata_d = st_wdata;
                    cnt_d   = '0;
                    berr_d  = 1'b0;
                    mis_d   = 1'b0;
                    state_d = REQ;
                    if (misal) begin
                        we_d    = 1'b0;
                        be_d    = 4'b0000;
                        ld_d    = '0;
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (!we_q) ld_d = ld_fmt;
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    ld_d    = '0;
                    berr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                berr_d  = 1'b0;
                mis_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            berr_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            berr_q  <= berr_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

    // The DONE cycle releases the core even if the request is still asserted
    assign Stall      = req & (state_q != DONE);
    assign Done       = (state_q == DONE);
    assign LoadData   = ld_q;
    assign BusErr     = berr_q;
    assign Misaligned = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Drives the core side and plays the memory through the bus interface.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] LoadData;
    logic        Stall;
    logic        Done;
    logic        BusErr;
    logic        Misaligned;

    int errors = 0;
    int checks = 0;

    load_store_unit_if bus();

    load_store_unit #(.ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .Addr       (Addr),
        .WrData     (WrData),
        .LoadData   (LoadData),
        .Stall      (Stall),
        .Done       (Done),
        .BusErr     (BusErr),
        .Misaligned (Misaligned),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp);
        Funct3  = f3;
        Addr    = a;
        MemRead = 1'b1;
        #1;
        check({tag, " stall c0"}, 32'(Stall), 32'd1);
        step();
        check({tag, " req c1"}, 32'(bus.mem_req), 32'd1);
        check({tag, " addr"}, bus.mem_addr, {a[31:2], 2'b00});
        check({tag, " be"}, 32'(bus.mem_be), 32'hF);
        check({tag, " we"}, 32'(bus.mem_we), 32'd0);
        bus.mem_rdata = rd;
        bus.mem_ack   = 1'b1;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        check({tag, " done c2"}, 32'(Done), 32'd1);
        check({tag, " data"}, LoadData, exp);
        check({tag, " berr"}, 32'(BusErr), 32'd0);
        check({tag, " mis"}, 32'(Misaligned), 32'd0);
        check({tag, " stall c2"}, 32'(Stall), 32'd0);
        MemRead = 1'b0;
        step();
        check({tag, " done c3"}, 32'(Done), 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] ewd);
        Funct3   = f3;
        Addr     = a;
        WrData   = wd;
        MemWrite = 1'b1;
        step();
        check({tag, " req"}, 32'(bus.mem_req), 32'd1);
        check({tag, " addr"}, bus.mem_addr, {a[31:2], 2'b00});
        check({tag, " be"}, 32'(bus.mem_be), 32'(be));
        check({tag, " wdata"}, bus.mem_wdata, ewd);
        check({tag, " we"}, 32'(bus.mem_we), 32'd1);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check({tag, " done"}, 32'(Done), 32'd1);
        check({tag, " berr"}, 32'(BusErr), 32'd0);
        MemWrite = 1'b0;
        step();
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        Funct3        = 3'b000;
        Addr          = 32'h0;
        WrData        = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;
        step();
        step();
        check("rst LoadData", LoadData, 32'h0);
        check("rst Done", 32'(Done), 32'd0);
        check("rst BusErr", 32'(BusErr), 32'd0);
        check("rst Misaligned", 32'(Misaligned), 32'd0);
        check("rst mem_req", 32'(bus.mem_req), 32'd0);
        check("rst mem_we", 32'(bus.mem_we), 32'd0);
        check("rst mem_be", 32'(bus.mem_be), 32'd0);
        reset = 1'b0;
        step();
        check("idle stall", 32'(Stall), 32'd0);

        do_load("LB",   3'b000, 32'h103, 32'h80FF_1234, 32'hFFFF_FF80);
        do_load("LHU",  3'b101, 32'h102, 32'h9ABC_0000, 32'h0000_9ABC);
        do_load("LH",   3'b001, 32'h100, 32'h0000_8001, 32'hFFFF_8001);
        do_load("LBU",  3'b100, 32'h101, 32'h0000_F700, 32'h0000_00F7);
        do_load("LW",   3'b010, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("LW011", 3'b011, 32'h108, 32'h1234_5678, 32'h1234_5678);

        do_store("SB", 3'b000, 32'h201, 32'hAABB_CC55, 4'b0010, 32'h5555_5555);
        do_store("SH", 3'b001, 32'h206, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("SW", 3'b010, 32'h208, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        step();
        check("idle ack done", 32'(Done), 32'd0);
        check("idle ack req", 32'(bus.mem_req), 32'd0);

        Funct3  = 3'b010;
        Addr    = 32'h300;
        MemRead = 1'b1;
        step();
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            step();
        end
        check("tmo req cycles", 32'(n), 32'd16);
        check("tmo done", 32'(Done), 32'd1);
        check("tmo berr", 32'(BusErr), 32'd1);
        check("tmo data", LoadData, 32'h0);
        MemRead = 1'b0;
        step();
        check("tmo idle done", 32'(Done), 32'd0);
        check("tmo idle berr", 32'(BusErr), 32'd0);

        Funct3  = 3'b010;
        Addr    = 32'h400;
        MemRead = 1'b1;
        step();
        check("rstmid req", 32'(bus.mem_req), 32'd1);
        step();
        reset   = 1'b1;
        MemRead = 1'b0;
        step();
        reset = 1'b0;
        check("rstmid req drop", 32'(bus.mem_req), 32'd0);
        check("rstmid done", 32'(Done), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        step();
        bus.mem_ack = 1'b0;
        check("late ack done", 32'(Done), 32'd0);
        check("late ack req", 32'(bus.mem_req), 32'd0);
        step();
        check("late ack done2", 32'(Done), 32'd0);

`ifdef MISALIGN_TRAP_EN
        Funct3  = 3'b010;
        Addr    = 32'h102;
        MemRead = 1'b1;
        step();
        check("mis req", 32'(bus.mem_req), 32'd0);
        check("mis done", 32'(Done), 32'd1);
        check("mis flag", 32'(Misaligned), 32'd1);
        check("mis data", LoadData, 32'h0);
        MemRead = 1'b0;
        step();
        check("mis clear", 32'(Misaligned), 32'd0);
`else
        do_load("LWmis", 3'b010, 32'h102, 32'h0BAD_F00D, 32'h0BAD_F00D);
        do_load("LHodd", 3'b001, 32'h103, 32'hF00D_0000, 32'hFFFF_F00D);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
